fp_result_checker: RTL and testbench

FP_RESULT_CHECKER -- requirements
Module: fp_result_checker

---
 rtl/fp_result_checker.sv | 168 ++++++++++++++++
 tb/tb_fp_result_checker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : fp_result_checker
// Brief    : In-order scoreboard comparing fp_unit results/flags against queued
//            expected vectors, with canonical-NaN tolerance and first-fail capture.
// Revision : 1.0
// ============================================================================
module fp_result_checker #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [63:0] issue_result,
  input  logic [4:0]  issue_flags,
  input  logic [1:0]  issue_fmt,
  input  logic [9:0]  issue_opcode,
  input  logic        issue_last,
  input  logic        ready,
  input  logic [63:0] result,
  input  logic [4:0]  flags,
  output logic        mismatch,
  output logic        done,
  output logic        fail,
  output logic        overflow,
  output logic        underflow,
  output logic [31:0] pass_count,
  output logic [15:0] error_count,
  output logic [6:0]  pending,
  output logic [63:0] ff_expected,
  output logic [63:0] ff_result,
  output logic [4:0]  ff_flags_diff
);
  localparam int         c_PTR_W   = $clog2(DEPTH);
  localparam int         c_ENTRY_W = 82;
  localparam logic [6:0] c_FULL    = 7'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_FAIL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_ENTRY_W-1:0] r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [6:0]           r_count;
  logic                 r_mismatch, r_fail, r_overflow, r_underflow;
  logic [31:0]          r_pass;
  logic [15:0]          r_error;
  logic [63:0]          r_ff_expected, r_ff_result;
  logic [4:0]           r_ff_flags_diff;

  logic [c_ENTRY_W-1:0] w_head;
  logic [63:0]          w_exp_result, w_res_diff;
  logic [4:0]           w_exp_flags, w_flags_diff;
  logic [1:0]           w_exp_fmt;
  logic [9:0]           w_exp_opcode;
  logic                 w_exp_last, w_bad;
  logic                 w_active, w_empty, w_full, w_pop, w_push, w_drop, w_under;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_exp_result = w_head[81:18];
  assign w_exp_flags  = w_head[17:13];
  assign w_exp_fmt    = w_head[12:11];
  assign w_exp_opcode = w_head[10:1];
  assign w_exp_last   = w_head[0];

  assign w_active = (r_state != ST_DONE);
  assign w_empty  = (r_count == 7'd0);
  assign w_full   = (r_count == c_FULL);
  assign w_pop    = w_active && ready && !w_empty;
  assign w_push   = w_active && issue_valid && (!w_full || w_pop);
  assign w_drop   = w_active && issue_valid && w_full && !w_pop;
  assign w_under  = w_active && ready && w_empty;

  // Canonical NaN from the unit is accepted against any NaN payload, except for
  // converts and compares whose integer/boolean result must match exactly.
  always_comb begin
    w_res_diff = result ^ w_exp_result;
    if (!w_exp_opcode[9] && !w_exp_opcode[6]) begin
      if (w_exp_fmt == 2'd0 && result[31:0] == 32'h7FC0_0000) begin
        w_res_diff        = '0;
        w_res_diff[30:22] = result[30:22] ^ w_exp_result[30:22];
      end else if (w_exp_fmt != 2'd0 && result == 64'h7FF8_0000_0000_0000) begin
        w_res_diff        = '0;
        w_res_diff[62:51] = result[62:51] ^ w_exp_result[62:51];
      end
    end
    w_flags_diff = flags ^ w_exp_flags;
    w_bad        = (|w_res_diff) || (|w_flags_diff);
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {issue_result, issue_flags, issue_fmt, issue_opcode, issue_last};
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_pop && w_exp_last)  w_state_nxt = ST_DONE;
        else if (w_pop && w_bad)  w_state_nxt = ST_FAIL;
      end
      ST_FAIL: begin
        if (w_pop && w_exp_last)  w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_mismatch      <= 1'b0;
      r_fail          <= 1'b0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
      r_pass          <= '0;
      r_error         <= '0;
      r_ff_expected   <= '0;
      r_ff_result     <= '0;
      r_ff_flags_diff <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 7'd1;
        2'b01:   r_count <= r_count - 7'd1;
        default: r_count <= r_count;
      endcase
      r_mismatch <= w_pop && w_bad;
      if (w_drop)  r_overflow  <= 1'b1;
      if (w_under) r_underflow <= 1'b1;
      if (w_pop && !w_bad && r_pass != 32'hFFFF_FFFF) r_pass <= r_pass + 32'd1;
      if (w_pop && w_bad) begin
        r_fail <= 1'b1;
        if (r_error != 16'hFFFF) r_error <= r_error + 16'd1;
        if (!r_fail) begin
          r_ff_expected   <= w_exp_result;
          r_ff_result     <= result;
          r_ff_flags_diff <= w_flags_diff;
        end
      end
    end
  end

  assign mismatch      = r_mismatch;
  assign done          = (r_state == ST_DONE);
  assign fail          = r_fail;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;
  assign pass_count    = r_pass;
  assign error_count   = r_error;
  assign pending       = r_count;
  assign ff_expected   = r_ff_expected;
  assign ff_result     = r_ff_result;
  assign ff_flags_diff = r_ff_flags_diff;

endmodule
`default_nettype wire

// File: tb/tb_fp_result_checker.sv
`default_nettype none
// Testbench for fp_result_checker: directed scenarios plus randomized streams
// checked every cycle against a queue-based reference model.
module tb_fp_result_checker;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [63:0] issue_result = '0;
  logic [4:0]  issue_flags = '0;
  logic [1:0]  issue_fmt = '0;
  logic [9:0]  issue_opcode = '0;
  logic        issue_last = 1'b0;
  logic        ready = 1'b0;
  logic [63:0] result = '0;
  logic [4:0]  flags = '0;
  logic        mismatch, done, fail, overflow, underflow;
  logic [31:0] pass_count;
  logic [15:0] error_count;
  logic [6:0]  pending;
  logic [63:0] ff_expected, ff_result;
  logic [4:0]  ff_flags_diff;

  fp_result_checker #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_result(issue_result), .issue_flags(issue_flags),
    .issue_fmt(issue_fmt), .issue_opcode(issue_opcode), .issue_last(issue_last),
    .ready(ready), .result(result), .flags(flags),
    .mismatch(mismatch), .done(done), .fail(fail), .overflow(overflow), .underflow(underflow),
    .pass_count(pass_count), .error_count(error_count), .pending(pending),
    .ff_expected(ff_expected), .ff_result(ff_result), .ff_flags_diff(ff_flags_diff)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] r;
    logic [4:0]  f;
    logic [1:0]  fm;
    logic [9:0]  op;
    bit          last;
  } entry_t;

  entry_t      mq[$];
  entry_t      m_e;
  bit          m_done, m_fail, m_over, m_under, m_mis;
  longint      m_pass, m_err;
  logic [63:0] m_ffe, m_ffr;
  logic [4:0]  m_fff;

  // Bits that must agree: all of them, or only the NaN-class field when the unit
  // returned the canonical NaN for an arithmetic op.
  function automatic bit ref_fails(entry_t e, logic [63:0] res, logic [4:0] fl);
    logic [63:0] care;
    care = '1;
    if (!e.op[9] && !e.op[6]) begin
      if (e.fm == 2'd0 && res[31:0] == 32'h7FC0_0000)                 care = 64'h0000_0000_7FC0_0000;
      else if (e.fm != 2'd0 && res == 64'h7FF8_0000_0000_0000)         care = 64'h7FF8_0000_0000_0000;
    end
    return (((res ^ e.r) & care) != 64'd0) || (fl != e.f);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      m_done = 0; m_fail = 0; m_over = 0; m_under = 0; m_mis = 0;
      m_pass = 0; m_err = 0; m_ffe = '0; m_ffr = '0; m_fff = '0;
    end else begin
      m_mis = 0;
      if (!m_done) begin
        if (ready && mq.size() == 0) m_under = 1;
        if (ready && mq.size() > 0) begin
          m_e = mq.pop_front();
          if (ref_fails(m_e, result, flags)) begin
            m_mis = 1;
            if (m_err < 65535) m_err++;
            if (!m_fail) begin m_ffe = m_e.r; m_ffr = result; m_fff = flags ^ m_e.f; end
            m_fail = 1;
          end else if (m_pass < 64'hFFFF_FFFF) m_pass++;
          if (m_e.last) m_done = 1;
        end
        if (issue_valid) begin
          if (mq.size() < DEPTH)
            mq.push_back('{r: issue_result, f: issue_flags, fm: issue_fmt, op: issue_opcode, last: issue_last});
          else m_over = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("mismatch", 64'(mismatch), 64'(m_mis));
      chk("done", 64'(done), 64'(m_done));
      chk("fail", 64'(fail), 64'(m_fail));
      chk("overflow", 64'(overflow), 64'(m_over));
      chk("underflow", 64'(underflow), 64'(m_under));
      chk("pass_count", 64'(pass_count), 64'(m_pass));
      chk("error_count", 64'(error_count), 64'(m_err));
      chk("pending", 64'(pending), 64'(mq.size()));
      chk("ff_expected", ff_expected, m_ffe);
      chk("ff_result", ff_result, m_ffr);
      chk("ff_flags_diff", 64'(ff_flags_diff), 64'(m_fff));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    issue_valid = 0; issue_last = 0; ready = 0;
  endtask

  task automatic cycle();
    @(posedge clock); #1; idle();
  endtask

  task automatic do_reset();
    reset = 1; idle(); cycle(); cycle(); reset = 0; chk_en = 1;
  endtask

  task automatic push(input logic [63:0] r, input logic [4:0] f, input logic [1:0] fm,
                      input logic [9:0] op, input bit last);
    issue_valid = 1; issue_result = r; issue_flags = f; issue_fmt = fm;
    issue_opcode = op; issue_last = last;
  endtask

  task automatic give(input logic [63:0] r, input logic [4:0] f);
    ready = 1; result = r; flags = f;
  endtask

  task automatic gen_issue(input bit last);
    logic [63:0] r;
    logic [1:0]  fm;
    fm = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    r  = {32'($urandom), 32'($urandom)};
    if ($urandom_range(0, 1) != 0)
      r = (fm == 2'd0) ? {32'($urandom), 32'h7FC0_0000 ^ (32'd1 << $urandom_range(0, 31))}
                       : 64'h7FF8_0000_0000_0000 ^ (64'd1 << $urandom_range(0, 63));
    push(r, ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(0, 31)), fm,
         10'd1 << $urandom_range(0, 9), last);
  endtask

  task automatic gen_result();
    entry_t e;
    if (mq.size() == 0) begin
      give({32'($urandom), 32'($urandom)}, 5'($urandom_range(0, 31)));
    end else begin
      e = mq[0];
      case ($urandom_range(0, 5))
        3:       give((e.fm == 2'd0) ? {32'($urandom), 32'h7FC0_0000} : 64'h7FF8_0000_0000_0000, e.f);
        4:       give(e.r ^ (64'd1 << $urandom_range(0, 63)), e.f);
        5:       give(e.r, e.f ^ (5'd1 << $urandom_range(0, 4)));
        default: give(e.r, e.f);
      endcase
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    entry_t pe;
    pe = '{r: 64'h7FC0_0001, f: 5'd0, fm: 2'd0, op: 10'h001, last: 1'b0};
    chk("model_nan_single_pass", 64'(ref_fails(pe, 64'h7FC0_0000, 5'd0)), 64'd0);
    pe.op = 10'h040;
    chk("model_nan_single_fcmp", 64'(ref_fails(pe, 64'h7FC0_0000, 5'd0)), 64'd1);
    pe = '{r: 64'h7FF8_0000_0000_0000, f: 5'h10, fm: 2'd1, op: 10'h001, last: 1'b0};
    chk("model_flags_diff", 64'(ref_fails(pe, 64'h7FF8_0000_0000_0000, 5'd0)), 64'd1);

    // reset state
    do_reset();
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_pass", 64'(pass_count), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // four matching vectors
    for (int i = 0; i < 4; i++) begin
      push(64'h4000_0000_0000_0000 + 64'(i), 5'(i), 2'd1, 10'h001, i == 3); cycle();
    end
    for (int i = 0; i < 4; i++) begin
      give(64'h4000_0000_0000_0000 + 64'(i), 5'(i)); cycle();
      if (i == 2) chk("basic_not_done_yet", 64'(done), 64'd0);
    end
    chk("basic_pass4", 64'(pass_count), 64'd4);
    chk("basic_err0", 64'(error_count), 64'd0);
    chk("basic_done", 64'(done), 64'd1);
    chk("basic_fail0", 64'(fail), 64'd0);

    // single-precision canonical NaN: tolerated for fadd, not for fcmp
    do_reset();
    push(64'h7FC0_0001, 5'd0, 2'd0, 10'h001, 0); cycle();
    push(64'h7FC0_0001, 5'd0, 2'd0, 10'h040, 1); cycle();
    give(64'h7FC0_0000, 5'd0); cycle();
    chk("nan_fadd_pass", 64'(pass_count), 64'd1);
    chk("nan_fadd_nomis", 64'(mismatch), 64'd0);
    give(64'h7FC0_0000, 5'd0); cycle();
    chk("nan_fcmp_mis", 64'(mismatch), 64'd1);
    chk("nan_fcmp_done", 64'(done), 64'd1);
    chk("nan_fcmp_fail", 64'(fail), 64'd1);
    chk("nan_ff_expected", ff_expected, 64'h7FC0_0001);
    chk("nan_ff_result", ff_result, 64'h7FC0_0000);

    // double precision flags mismatch, then a second failure
    do_reset();
    push(64'h7FF8_0000_0000_0000, 5'h10, 2'd1, 10'h001, 0); cycle();
    push(64'h3FF0_0000_0000_0000, 5'h00, 2'd1, 10'h001, 0); cycle();
    give(64'h7FF8_0000_0000_0000, 5'h00); cycle();
    chk("dbl_mis", 64'(mismatch), 64'd1);
    chk("dbl_ff_flags", 64'(ff_flags_diff), 64'h10);
    chk("dbl_fail", 64'(fail), 64'd1);
    cycle();
    chk("dbl_mis_pulse", 64'(mismatch), 64'd0);
    give(64'h4000_0000_0000_0000, 5'h00); cycle();
    chk("dbl_err2", 64'(error_count), 64'd2);
    chk("dbl_ff_frozen", ff_result, 64'h7FF8_0000_0000_0000);
    chk("dbl_ff_flags_frozen", 64'(ff_flags_diff), 64'h10);

    // overflow behaviour at DEPTH entries
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin push(64'(i), 5'd0, 2'd1, 10'h001, 0); cycle(); end
    chk("full_pending", 64'(pending), 64'(DEPTH));
    chk("full_no_ovf", 64'(overflow), 64'd0);
    push(64'd100, 5'd0, 2'd1, 10'h001, 0); give(64'd0, 5'd0); cycle();
    chk("full_pushpop_pending", 64'(pending), 64'(DEPTH));
    chk("full_pushpop_no_ovf", 64'(overflow), 64'd0);
    push(64'd101, 5'd0, 2'd1, 10'h001, 0); cycle();
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_pending", 64'(pending), 64'(DEPTH));

    // underflow with same-cycle push, then mid-stream reset
    do_reset();
    push(64'd7, 5'd0, 2'd0, 10'h001, 0); give(64'd7, 5'd0); cycle();
    chk("unf_set", 64'(underflow), 64'd1);
    chk("unf_stored", 64'(pending), 64'd1);
    chk("unf_no_count", 64'(pass_count) + 64'(error_count), 64'd0);
    push(64'd8, 5'd0, 2'd0, 10'h001, 0); cycle();
    push(64'd9, 5'd0, 2'd0, 10'h001, 0); cycle();
    chk("pre_rst_pending", 64'(pending), 64'd3);
    reset = 1; cycle(); reset = 0;
    chk("mid_rst_pending", 64'(pending), 64'd0);
    chk("mid_rst_underflow", 64'(underflow), 64'd0);

    // randomized streams
    for (int rnd = 0; rnd < 10; rnd++) begin
      int n, issued, extra, rp;
      do_reset();
      n = $urandom_range(3, 30); issued = 0; extra = 0;
      rp = (rnd % 3 == 0) ? 20 : (rnd % 3 == 1) ? 55 : 90;
      for (int cyc = 0; cyc < 400 && extra < 8; cyc++) begin
        if (issued < n) begin
          if ($urandom_range(0, 99) < 60) begin gen_issue(issued == n - 1); issued++; end
        end else if ($urandom_range(0, 99) < 30) begin
          gen_issue($urandom_range(0, 1) != 0);
        end
        if ($urandom_range(0, 99) < rp) gen_result();
        cycle();
        if (m_done) extra++;
      end
    end

    @(negedge clock);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
